// File: rtl/alpha_coef_pkg.sv
// alpha_coef_pkg: shared constants for the reloadable alpha coefficient buffer.
//   - default coefficient width / depth shared with the BWN scale stage
//   - burst sequencer FSM state encoding
//   - clog2 helper (never returns less than 1 so a 1-entry array still gets an index bit)
package alpha_coef_pkg;

  localparam int ALPHA_DATA_W = 16;
  localparam int ALPHA_DEPTH  = 80;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alpha_coef_buffer_regfile.sv
// coef_regfile: DEPTH x DATA_W coefficient storage.
//   gclk   : clock
//   we     : write strobe (caller guarantees waddr < DEPTH)
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index (caller guarantees raddr < DEPTH)
//   rdata  : combinational read data
// Storage has no reset. Because the read is combinational and the write lands
// on the clock edge, a same-cycle read of the written entry returns old data.
module coef_regfile
  import alpha_coef_pkg::*;
#(
  parameter int DATA_W = ALPHA_DATA_W,
  parameter int DEPTH  = ALPHA_DEPTH,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic              gclk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alpha_coef_buffer.sv
// alpha_coef_buffer: run-time loadable alpha coefficient buffer with a
// wrap-around burst streamer feeding the MAC/scale stage.
//   clk, rst_n         : clock, async active-low reset
//   wr_en/addr/data    : coefficient load port (out-of-range address -> err)
//   start, base_addr,
//   burst_len          : burst request, sampled only when idle
//   busy, done         : burst in progress / one-cycle completion pulse
//   coef_valid/ready,
//   coef, coef_last    : registered output stream, valid/ready handshake
//   err, err_clr       : sticky error flag and its clear (set wins over clear)
module alpha_coef_buffer
  import alpha_coef_pkg::*;
#(
  parameter int DATA_W = ALPHA_DATA_W,
  parameter int DEPTH  = ALPHA_DEPTH,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] burst_len,
  output logic              busy,
  output logic              done,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [DATA_W-1:0] coef,
  output logic              coef_last,
  output logic              err,
  input  logic              err_clr
);

  localparam int IDX_W = clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt, remaining;
  logic [DATA_W-1:0] rd_data;
  logic              idle_free, wr_ok, wr_bad, start_bad, start_ok, load, accept;

  // IDLE with busy set is the one-cycle arm slot between an accepted start and
  // RUN; start is ignored there just as in RUN/DRAIN.
  assign idle_free = (state == ST_IDLE) && !busy;
  assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign wr_bad    = wr_en && !wr_ok;
  assign start_bad = idle_free && start && ({1'b0, base_addr} >= DEPTH_C);
  assign start_ok  = idle_free && start && !start_bad && (burst_len != '0);
  assign load      = (state == ST_RUN) && (!coef_valid || coef_ready) && (remaining != '0);
  assign accept    = coef_valid && coef_ready;
  assign rd_ptr_nxt = ({1'b0, rd_ptr} == LAST_C) ? '0 : rd_ptr + 1'b1;

  coef_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .gclk  (clk),
    .we    (wr_ok),
    .waddr (wr_addr[IDX_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      coef_valid <= 1'b0;
      coef       <= '0;
      coef_last  <= 1'b0;
      err        <= 1'b0;
      rd_ptr     <= '0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;

      if (wr_bad || start_bad) err <= 1'b1;
      else if (err_clr)        err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (busy) begin
            state <= ST_RUN;
          end else if (start_ok) begin
            busy      <= 1'b1;
            rd_ptr    <= base_addr;
            remaining <= burst_len;
          end
        end
        ST_RUN: begin
          if (load) begin
            coef       <= rd_data;
            coef_valid <= 1'b1;
            coef_last  <= (remaining == ADDR_W'(1));
            rd_ptr     <= rd_ptr_nxt;
            remaining  <= remaining - 1'b1;
            if (remaining == ADDR_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (accept) begin
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
